int_to_float: RTL and testbench

Single-precision integer-to-IEEE-754 converter. It accepts a 32-bit two's-complement integer on a strobe/acknowledge input port and returns the nearest single-precision float, rounded to nearest with ties to even, on a strobe/acknowledge output port. It is the inverse companion of the float-to-integer converter and plugs into the same handshake fabric as the other FPU blocks. It uses a serial normaliser: one shift per clock.

---
 rtl/int_to_float.sv | 152 +++++++++++++++
 tb/tb_int_to_float.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// ============================================================================
//  Module   : int_to_float
//  Brief    : 32-bit two's-complement integer to IEEE-754 single converter,
//             round to nearest even, serial normaliser (one shift per clock).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        S_GET_A     = 3'd0,
        S_CONVERT_0 = 3'd1,
        S_NORMALISE = 3'd2,
        S_ROUND     = 3'd3,
        S_PACK      = 3'd4,
        S_PUT_Z     = 3'd5
    } state_t;

    localparam logic signed [8:0] c_E_INIT = 9'sd31;
    localparam logic signed [8:0] c_BIAS   = 9'sd127;

    state_t             r_state, w_state;
    logic [31:0]        r_a, w_a;
    logic [31:0]        r_value, w_value;
    logic signed [8:0]  r_e, w_e;
    logic [23:0]        r_m, w_m;
    logic               r_sign, w_sign;
    logic [31:0]        r_z, w_z;
    logic               r_ack, w_ack;
    logic               r_stb, w_stb;
    logic [31:0]        r_out, w_out;
    logic [24:0]        w_sum;
    logic               w_round_up;

    assign input_a_ack  = r_ack;
    assign output_z_stb = r_stb;
    assign output_z     = r_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_GET_A;
            r_a     <= '0;
            r_value <= '0;
            r_e     <= '0;
            r_m     <= '0;
            r_sign  <= 1'b0;
            r_z     <= '0;
            r_ack   <= 1'b0;
            r_stb   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_state;
            r_a     <= w_a;
            r_value <= w_value;
            r_e     <= w_e;
            r_m     <= w_m;
            r_sign  <= w_sign;
            r_z     <= w_z;
            r_ack   <= w_ack;
            r_stb   <= w_stb;
            r_out   <= w_out;
        end
    end

    // Mantissa is value[31:8]; bit 7 guard, bit 6 round, [5:0] sticky.
    assign w_sum      = {1'b0, r_value[31:8]} + 25'd1;
    assign w_round_up = r_value[7] && (r_value[6] || (|r_value[5:0]) || r_value[8]);

    always_comb begin
        w_state = r_state;
        w_a     = r_a;
        w_value = r_value;
        w_e     = r_e;
        w_m     = r_m;
        w_sign  = r_sign;
        w_z     = r_z;
        w_ack   = r_ack;
        w_stb   = r_stb;
        w_out   = r_out;

        case (r_state)
            S_GET_A: begin
                w_ack = 1'b1;
                if (r_ack && input_a_stb) begin
                    w_a     = input_a;
                    w_ack   = 1'b0;
                    w_state = S_CONVERT_0;
                end
            end
            S_CONVERT_0: begin
                w_sign  = r_a[31];
                w_value = r_a[31] ? (~r_a + 32'd1) : r_a;
                w_e     = c_E_INIT;
                if (r_a == 32'd0) begin
                    w_z     = 32'd0;
                    w_state = S_PUT_Z;
                end else begin
                    w_state = S_NORMALISE;
                end
            end
            S_NORMALISE: begin
                if (!r_value[31]) begin
                    w_value = {r_value[30:0], 1'b0};
                    w_e     = r_e - 9'sd1;
                end else begin
                    w_state = S_ROUND;
                end
            end
            S_ROUND: begin
                w_m = r_value[31:8];
                if (w_round_up) begin
                    // A carry out of 0xFFFFFF leaves the low 24 bits zero; the
                    // hidden bit is implicit, so only the exponent needs bumping.
                    w_m = w_sum[23:0];
                    w_e = r_e + {8'd0, w_sum[24]};
                end
                w_state = S_PACK;
            end
            S_PACK: begin
                w_z     = {r_sign, 8'(r_e + c_BIAS), 23'(r_m)};
                w_state = S_PUT_Z;
            end
            S_PUT_Z: begin
                if (r_stb && output_z_ack) begin
                    w_stb   = 1'b0;
                    w_state = S_GET_A;
                end else begin
                    w_stb = 1'b1;
                    w_out = r_z;
                end
            end
            default: begin
                w_state = S_GET_A;
                w_ack   = 1'b0;
                w_stb   = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_int_to_float.sv
// ============================================================================
//  Module   : tb_int_to_float
//  Brief    : Self-checking bench for int_to_float: directed corner cases,
//             backpressure, mid-conversion reset and a random sweep.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_to_float;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic [31:0] input_a      = '0;
    logic        input_a_stb  = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact integer rounding: keep the top 24 significant bits, compare the
    // discarded remainder with half an ulp, break ties toward an even result.
    function automatic void ref_model(input logic [31:0] a, output logic [31:0] z,
                                      output int lat);
        longint mag, q, rem, half;
        int     p, shift;
        logic   s;
        if (a == 32'd0) begin
            z   = 32'd0;
            lat = 2;
            return;
        end
        s   = a[31];
        mag = s ? (64'sd4294967296 - longint'({32'd0, a})) : longint'({32'd0, a});
        p   = 0;
        for (int i = 0; i < 32; i++)
            if (mag >= (64'sd1 << i)) p = i;
        lat = 5 + (31 - p);
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            shift = p - 23;
            q     = mag >> shift;
            rem   = mag - (q << shift);
            half  = 64'sd1 << (shift - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            p = p + 1;
        end
        z = {s, 8'(p + 127), 23'(q)};
    endfunction

    task automatic do_conv(input logic [31:0] a, input logic [31:0] exp_z, input int exp_lat,
                           input int idle, input int ack_gap, input string tag);
        int w;
        int lat;
        w = 0;
        @(negedge clk);
        while (!input_a_ack && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!input_a_ack) begin
            check({tag, " ack_timeout"}, 32'(input_a_ack), 32'd1);
            return;
        end
        repeat (idle) @(negedge clk);
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        input_a     = $urandom;
        check({tag, " ack_drop"}, 32'(input_a_ack), 32'd0);

        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (output_z_stb) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (!output_z_stb) return;
        check({tag, " result"}, output_z, exp_z);

        repeat (ack_gap) begin
            @(posedge clk);
            #1;
            check({tag, " hold_stb"}, 32'(output_z_stb), 32'd1);
            check({tag, " hold_z"}, output_z, exp_z);
            check({tag, " hold_ack"}, 32'(input_a_ack), 32'd0);
        end

        @(negedge clk);
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        check({tag, " release_stb"}, 32'(output_z_stb), 32'd0);
        check({tag, " release_ack"}, 32'(input_a_ack), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " rearm_ack"}, 32'(input_a_ack), 32'd1);
        check({tag, " z_retained"}, output_z, exp_z);
    endtask

    task automatic do_rand(input logic [31:0] a, input int idle, input int ack_gap, input string tag);
        logic [31:0] z;
        int          lat;
        ref_model(a, z, lat);
        do_conv(a, z, lat, idle, ack_gap, tag);
    endtask

    initial begin
        logic [31:0] ra;

        repeat (3) @(posedge clk);
        #1;
        check("reset ack", 32'(input_a_ack), 32'd0);
        check("reset stb", 32'(output_z_stb), 32'd0);
        check("reset z", output_z, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset ack", 32'(input_a_ack), 32'd1);

        do_conv(32'h0000_0001, 32'h3F80_0000, 36, 0, 0, "one");
        do_conv(32'hFFFF_FFFF, 32'hBF80_0000, 36, 0, 1, "minus_one");
        do_conv(32'h0000_0000, 32'h0000_0000, 2, 1, 0, "zero");
        do_conv(32'h8000_0000, 32'hCF00_0000, 5, 0, 0, "int_min");
        do_conv(32'h7FFF_FFFF, 32'h4F00_0000, 6, 0, 2, "int_max");
        do_conv(32'h0100_0001, 32'h4B80_0000, 12, 0, 0, "tie_even");
        do_conv(32'h0100_0003, 32'h4B80_0002, 12, 0, 0, "tie_odd");
        do_conv(32'h0100_0005, 32'h4B80_0002, 12, 0, 0, "tie_even2");
        do_conv(-32'sd16777219, 32'hCB80_0002, 12, 0, 0, "tie_neg");
        do_conv(32'h0100_0003, 32'h4B80_0002, 12, 0, 20, "backpressure");

        // Reset in the middle of normalising an operand of 1.
        @(negedge clk);
        input_a     = 32'h0000_0001;
        input_a_stb = 1'b1;
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            check("midrst no_stb", 32'(output_z_stb), 32'd0);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst ack", 32'(input_a_ack), 32'd0);
        check("midrst stb", 32'(output_z_stb), 32'd0);
        check("midrst z", output_z, 32'd0);
        @(posedge clk);
        #1;
        check("midrst held_ack", 32'(input_a_ack), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst rearm", 32'(input_a_ack), 32'd1);
        check("midrst no_emit", 32'(output_z_stb), 32'd0);
        do_conv(32'h0000_0064, 32'h42C8_0000, 30, 0, 0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 9) == 0) ra = 32'd0;
            do_rand(ra, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
